// File: rtl/pc_fetch_if.sv
// Fetch-control bus: run handshake, decoder inputs, LUT port and PC outputs.
// master = top level / testbench side, slave = pc_fetch_ctrl side.
interface pc_fetch_if #(
  parameter int D     = 10,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             branch_taken;
  logic [IDX_W-1:0] lut_idx;
  logic [IDX_W-1:0] lut_addr;
  logic [D-1:0]     lut_target;
  logic [D-1:0]     pc;
  logic             pc_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, halt, stall,
    output branch_taken, lut_idx,
    output lut_target,
    input  lut_addr, pc, pc_valid,
    input  done, cycle_cnt
  );

  modport slave (
    input  start, halt, stall,
    input  branch_taken, lut_idx,
    input  lut_target,
    output lut_addr, pc, pc_valid,
    output done, cycle_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: IDLE/RUN/HALTED run control, +1 or LUT-branch next PC,
// saturating RUN cycle counter. Ports: clk, reset_n, bus (pc_fetch_if.slave).
module pc_fetch_ctrl #(
  parameter int             D        = 10,
  parameter int             IDX_W    = 8,
  parameter logic [D-1:0]   START_PC = '0,
  parameter int             CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  pc_fetch_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             run;

  assign run = (state_q == S_RUN);

  // LUT index passes straight through so the target
  // returns in the same cycle the branch is decided.
  assign bus.lut_addr  = run ? bus.lut_idx : '0;
  assign bus.pc_valid  = run && !bus.stall;
  assign bus.pc        = pc_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      S_RUN: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
        // halt outranks stall and branch
        if (bus.halt) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.branch_taken) begin
          pc_d = bus.lut_target;
        end else begin
          pc_d = pc_q + D'(1);
        end
      end
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
